sha_sigma_pipe: RTL and testbench

//  Parametrised, pipelined rotate/shift and SHA-2 sigma unit for the miner datapath.

---
 rtl/sha_sigma_pkg.sv | 35 +++
 rtl/rotr_var.sv | 16 +
 rtl/sha_sigma_pipe.sv | 156 +++++++++++++++
 tb/tb_sha_sigma_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_sigma_pkg.sv
// Shared op codes and SHA-2 sigma rotate/shift tables for the rotate/sigma pipeline.
// Table rows are S0, S1, s0, s1; columns are terms A, B, C (C is a right shift for s0/s1).
package sha_sigma_pkg;

  localparam logic [2:0] OP_ROTR = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_S0B  = 3'd2;
  localparam logic [2:0] OP_S1B  = 3'd3;
  localparam logic [2:0] OP_S0S  = 3'd4;
  localparam logic [2:0] OP_S1S  = 3'd5;

  localparam int SIG32 [4][3] = '{'{2, 13, 22}, '{6, 11, 25}, '{7, 18, 3}, '{17, 19, 10}};
  localparam int SIG64 [4][3] = '{'{28, 34, 39}, '{14, 18, 41}, '{1, 8, 7}, '{19, 61, 6}};

  function automatic logic is_sigma(input logic [2:0] op);
    return (op == OP_S0B) || (op == OP_S1B) || (op == OP_S0S) || (op == OP_S1S);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

  // Term C of the small sigmas is a logical shift, not a rotate.
  function automatic logic term_c_is_shr(input logic [2:0] op);
    return (op == OP_S0S) || (op == OP_S1S);
  endfunction

  function automatic int sigma_amt(input int width, input logic [2:0] op, input int term);
    logic [1:0] row;
    row = 2'(op - 3'd2);
    if (!is_sigma(op)) return 0;
    return (width == 64) ? SIG64[row][term] : SIG32[row][term];
  endfunction

endpackage

// File: rtl/rotr_var.sv
// Combinational right-rotator: rotates data_i right by amt_i positions (modulo WIDTH).
module rotr_var #(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW-1:0]    amt_i,
  output logic [WIDTH-1:0] rot_o
);

  logic [2*WIDTH-1:0] dbl;

  assign dbl   = {data_i, data_i} >> amt_i;
  assign rot_o = dbl[WIDTH-1:0];

endmodule

// File: rtl/sha_sigma_pipe.sv
// Pipelined run-time ROTR/SHR and SHA-2 sigma unit with valid/ready flow control.
// Stage 0 captures the three rotated terms; the last stage holds their XOR.
module sha_sigma_pipe
  import sha_sigma_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err,
  output logic                     busy
);

  localparam int AW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("sha_sigma_pipe: WIDTH must be 32 or 64");
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("sha_sigma_pipe: PIPE_STAGES must be 1 or 2");
  end

  logic [AW-1:0]    amt_a, amt_b, amt_c;
  logic [WIDTH-1:0] rot_a, rot_b, rot_c;
  logic [WIDTH-1:0] term_a, term_b, term_c;
  logic             err_in;

  always_comb begin
    amt_a  = ((in_op == OP_ROTR) || (in_op == OP_SHR)) ? in_amt
                                                       : AW'(sigma_amt(WIDTH, in_op, 0));
    amt_b  = AW'(sigma_amt(WIDTH, in_op, 1));
    amt_c  = AW'(sigma_amt(WIDTH, in_op, 2));
    err_in = is_reserved(in_op);
    term_a = '0;
    term_b = '0;
    term_c = '0;
    if (in_op == OP_ROTR) begin
      term_a = rot_a;
    end else if (in_op == OP_SHR) begin
      term_a = rot_a & (ONES >> in_amt);
    end else if (is_sigma(in_op)) begin
      term_a = rot_a;
      term_b = rot_b;
      term_c = term_c_is_shr(in_op) ? (rot_c & (ONES >> amt_c)) : rot_c;
    end
  end

  rotr_var #(.WIDTH(WIDTH), .AW(AW)) u_rot_a (.data_i(in_data), .amt_i(amt_a), .rot_o(rot_a));
  rotr_var #(.WIDTH(WIDTH), .AW(AW)) u_rot_b (.data_i(in_data), .amt_i(amt_b), .rot_o(rot_b));
  rotr_var #(.WIDTH(WIDTH), .AW(AW)) u_rot_c (.data_i(in_data), .amt_i(amt_c), .rot_o(rot_c));

  logic             vld_last;
  logic [WIDTH-1:0] data_last;
  logic [TAG_W-1:0] tag_last;
  logic             err_last;

  if (PIPE_STAGES == 2) begin : g_two
    logic             vld_p0_q, vld_p1_q;
    logic [WIDTH-1:0] a_p0_q, b_p0_q, c_p0_q;
    logic [TAG_W-1:0] tag_p0_q, tag_p1_q;
    logic             err_p0_q, err_p1_q;
    logic [WIDTH-1:0] data_p1_q, data_p1_d;
    logic             ld_p0, ld_p1;

    assign ld_p1     = !vld_p1_q || out_ready;
    assign ld_p0     = !vld_p0_q || ld_p1;
    assign data_p1_d = a_p0_q ^ b_p0_q ^ c_p0_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p0_q <= 1'b0;
        vld_p1_q <= 1'b0;
      end else begin
        if (ld_p0) vld_p0_q <= in_valid;
        if (ld_p1) vld_p1_q <= vld_p0_q;
      end
    end

    // stage 0: rotated terms
    always_ff @(posedge clk) begin
      if (ld_p0 && in_valid) begin
        a_p0_q   <= term_a;
        b_p0_q   <= term_b;
        c_p0_q   <= term_c;
        tag_p0_q <= in_tag;
        err_p0_q <= err_in;
      end
    end

    // stage 1: combined result
    always_ff @(posedge clk) begin
      if (ld_p1 && vld_p0_q) begin
        data_p1_q <= data_p1_d;
        tag_p1_q  <= tag_p0_q;
        err_p1_q  <= err_p0_q;
      end
    end

    assign in_ready  = ld_p0;
    assign busy      = vld_p0_q || vld_p1_q;
    assign vld_last  = vld_p1_q;
    assign data_last = data_p1_q;
    assign tag_last  = tag_p1_q;
    assign err_last  = err_p1_q;
  end else begin : g_one
    logic             vld_p0_q;
    logic [WIDTH-1:0] data_p0_q, data_p0_d;
    logic [TAG_W-1:0] tag_p0_q;
    logic             err_p0_q;
    logic             ld_p0;

    assign ld_p0     = !vld_p0_q || out_ready;
    assign data_p0_d = term_a ^ term_b ^ term_c;

    always_ff @(posedge clk) begin
      if (reset) vld_p0_q <= 1'b0;
      else if (ld_p0) vld_p0_q <= in_valid;
    end

    // stage 0: combined result
    always_ff @(posedge clk) begin
      if (ld_p0 && in_valid) begin
        data_p0_q <= data_p0_d;
        tag_p0_q  <= in_tag;
        err_p0_q  <= err_in;
      end
    end

    assign in_ready  = ld_p0;
    assign busy      = vld_p0_q;
    assign vld_last  = vld_p0_q;
    assign data_last = data_p0_q;
    assign tag_last  = tag_p0_q;
    assign err_last  = err_p0_q;
  end

  // Result fields read as zero whenever no result is presented, including after reset.
  assign out_valid = vld_last;
  assign out_data  = vld_last ? data_last : '0;
  assign out_tag   = vld_last ? tag_last : '0;
  assign out_err   = vld_last && err_last;

endmodule

// File: tb/tb_sha_sigma_pipe.sv
// Bench for sha_sigma_pipe: a 32-bit two-stage instance and a 64-bit single-stage instance.
module tb_sha_sigma_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        i32_valid = 0, i32_ready, o32_valid, o32_ready = 1, o32_err, busy32;
  logic [2:0]  i32_op = 0;
  logic [4:0]  i32_amt = 0;
  logic [31:0] i32_data = 0, o32_data;
  logic [3:0]  i32_tag = 0, o32_tag;

  logic        i64_valid = 0, i64_ready, o64_valid, o64_ready = 1, o64_err, busy64;
  logic [2:0]  i64_op = 0;
  logic [5:0]  i64_amt = 0;
  logic [63:0] i64_data = 0, o64_data;
  logic [3:0]  i64_tag = 0, o64_tag;

  sha_sigma_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(i32_valid), .in_ready(i32_ready), .in_op(i32_op),
    .in_amt(i32_amt), .in_data(i32_data), .in_tag(i32_tag), .out_valid(o32_valid),
    .out_ready(o32_ready), .out_data(o32_data), .out_tag(o32_tag), .out_err(o32_err), .busy(busy32));

  sha_sigma_pipe #(.WIDTH(64), .PIPE_STAGES(1), .TAG_W(4)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(i64_valid), .in_ready(i64_ready), .in_op(i64_op),
    .in_amt(i64_amt), .in_data(i64_data), .in_tag(i64_tag), .out_valid(o64_valid),
    .out_ready(o64_ready), .out_data(o64_data), .out_tag(o64_tag), .out_err(o64_err), .busy(busy64));

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [63:0] d; logic [3:0] t; logic e; } exp_t;

  // Reference model: bit i of ROTR(x,n) is bit (i+n) mod w of x; SHR zero-fills the top.
  function automatic logic [63:0] m_rotr(input int w, input logic [63:0] x, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = x[(i + n) % w];
    return r;
  endfunction

  function automatic logic [63:0] m_shr(input int w, input logic [63:0] x, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = (i + n < w) ? x[i + n] : 1'b0;
    return r;
  endfunction

  function automatic logic [63:0] model(input int w, input int op, input int amt,
                                        input logic [63:0] xin, output logic err);
    logic [63:0] x;
    x = (w == 32) ? {32'h0, xin[31:0]} : xin;
    err = 1'b0;
    case (op)
      0: return m_rotr(w, x, amt % w);
      1: return m_shr(w, x, amt % w);
      2: return (w == 32) ? m_rotr(w, x, 2) ^ m_rotr(w, x, 13) ^ m_rotr(w, x, 22)
                          : m_rotr(w, x, 28) ^ m_rotr(w, x, 34) ^ m_rotr(w, x, 39);
      3: return (w == 32) ? m_rotr(w, x, 6) ^ m_rotr(w, x, 11) ^ m_rotr(w, x, 25)
                          : m_rotr(w, x, 14) ^ m_rotr(w, x, 18) ^ m_rotr(w, x, 41);
      4: return (w == 32) ? m_rotr(w, x, 7) ^ m_rotr(w, x, 18) ^ m_shr(w, x, 3)
                          : m_rotr(w, x, 1) ^ m_rotr(w, x, 8) ^ m_shr(w, x, 7);
      5: return (w == 32) ? m_rotr(w, x, 17) ^ m_rotr(w, x, 19) ^ m_shr(w, x, 10)
                          : m_rotr(w, x, 19) ^ m_rotr(w, x, 61) ^ m_shr(w, x, 6);
      default: begin err = 1'b1; return '0; end
    endcase
  endfunction

  // Drives one op into the chosen instance with out_ready high and collects its result.
  task automatic run_op(input bit w64, input logic [2:0] op, input int amt, input logic [63:0] d,
                        input logic [3:0] tg, output logic [63:0] rd, output logic [3:0] rt,
                        output logic re, output int lat, output bit ok);
    bit acc;
    acc = 0; ok = 0; rd = '0; rt = '0; re = 0; lat = 0;
    @(negedge clk);
    if (w64) begin
      i64_valid = 1; i64_op = op; i64_amt = 6'(amt); i64_data = d; i64_tag = tg; o64_ready = 1;
    end else begin
      i32_valid = 1; i32_op = op; i32_amt = 5'(amt); i32_data = d[31:0]; i32_tag = tg; o32_ready = 1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (w64 ? i64_ready : i32_ready) begin acc = 1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    i32_valid = 0;
    i64_valid = 0;
    if (!acc) return;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (w64 ? o64_valid : o32_valid) begin
        rd = w64 ? o64_data : {32'h0, o32_data};
        rt = w64 ? o64_tag : o32_tag;
        re = w64 ? o64_err : o32_err;
        ok = 1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (o32_valid !== 0 || busy32 !== 0 || o32_data !== 0 || o32_tag !== 0 || o32_err !== 0)
      begin n_err++; $display("FAIL reset32_outputs: valid=%b busy=%b data=%h tag=%h err=%b want all zero",
                             o32_valid, busy32, o32_data, o32_tag, o32_err); end
    n_vec++;
    if (o64_valid !== 0 || busy64 !== 0 || o64_data !== 0 || o64_tag !== 0 || o64_err !== 0)
      begin n_err++; $display("FAIL reset64_outputs: valid=%b busy=%b data=%h tag=%h err=%b want all zero",
                             o64_valid, busy64, o64_data, o64_tag, o64_err); end
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (i32_ready !== 1 || i64_ready !== 1)
      begin n_err++; $display("FAIL reset_in_ready: got %b/%b want 1/1", i32_ready, i64_ready); end
  endtask

  task automatic test_directed(input bit w64);
    logic [2:0]  ops  [9] = '{0, 0, 1, 2, 3, 4, 5, 6, 7};
    int          amts [9] = '{6, 0, 0, 13, 13, 13, 13, 13, 5};
    logic [63:0] d32  [9] = '{64'h1, 64'h1, 64'h80000000, 64'h1, 64'h1, 64'h80000000, 64'h1,
                              64'hDEADBEEF, 64'h12345678};
    logic [63:0] e32  [9] = '{64'h04000000, 64'h1, 64'h1, 64'h40080400, 64'h04200080,
                              64'h11002000, 64'h0000A000, 64'h0, 64'h0};
    logic [63:0] d64  [9] = '{64'h1, 64'h1, 64'h8000000000000000, 64'h1, 64'h1,
                              64'h8000000000000000, 64'h1, 64'hDEADBEEFCAFEF00D, 64'hFFFFFFFFFFFFFFFF};
    logic [63:0] e64  [9] = '{64'h0400000000000000, 64'h1, 64'h1, 64'h0000001042000000,
                              64'h0004400000800000, 64'h4180000000000000, 64'h0000200000000008,
                              64'h0, 64'h0};
    logic [63:0] rd, ed;
    logic [3:0]  rt;
    logic        re, ee;
    int          lat, am;
    bit          ok;
    for (int k = 0; k < 9; k++) begin
      am = (w64 && k == 2) ? 63 : (k == 2 ? 31 : amts[k]);
      ed = w64 ? e64[k] : e32[k];
      ee = (k >= 7);
      run_op(w64, ops[k], am, w64 ? d64[k] : d32[k], 4'(k + 3), rd, rt, re, lat, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL dir%0d_%0d_timeout: no result within bound", w64 ? 64 : 32, k); end
      else begin
        n_vec++;
        if (rd !== ed || re !== ee || rt !== 4'(k + 3))
          begin n_err++; $display("FAIL dir%0d_%0d: data=%h err=%b tag=%h want data=%h err=%b tag=%h",
                                 w64 ? 64 : 32, k, rd, re, rt, ed, ee, 4'(k + 3)); end
        n_vec++;
        if (lat !== (w64 ? 1 : 2))
          begin n_err++; $display("FAIL dir%0d_%0d_latency: got %0d want %0d", w64 ? 64 : 32, k, lat, w64 ? 1 : 2); end
      end
    end
  endtask

  task automatic test_random(input bit w64, input int n);
    logic [63:0] rd, ed, d;
    logic [3:0]  rt, tg;
    logic        re, ee;
    logic [2:0]  op;
    int          lat, am;
    bit          ok;
    for (int k = 0; k < n; k++) begin
      op = 3'($urandom_range(0, 7));
      am = $urandom_range(0, w64 ? 63 : 31);
      d  = {32'($urandom), 32'($urandom)};
      tg = 4'($urandom);
      ed = model(w64 ? 64 : 32, int'(op), am, d, ee);
      run_op(w64, op, am, d, tg, rd, rt, re, lat, ok);
      n_vec++;
      if (!ok || rd !== ed || re !== ee || rt !== tg)
        begin n_err++; $display("FAIL rand%0d op=%0d amt=%0d d=%h: ok=%b data=%h err=%b tag=%h want %h %b %h",
                               w64 ? 64 : 32, op, am, d, ok, rd, re, rt, ed, ee, tg); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t        q[$];
    exp_t        x;
    logic [2:0]  op [8];
    int          am [8];
    logic [31:0] dd [8];
    int          sent, recv;
    logic        held, held_e;
    logic [31:0] held_d;
    logic [3:0]  held_t;
    for (int k = 0; k < 8; k++) begin
      op[k] = 3'($urandom_range(0, 7)); am[k] = $urandom_range(0, 31); dd[k] = $urandom;
    end
    sent = 0; recv = 0; held = 0; held_d = 0; held_t = 0; held_e = 0;
    for (int c = 0; c < 80 && recv < 8; c++) begin
      @(negedge clk);
      o32_ready = (c % 4 == 0) || (c % 4 == 3);
      if (sent < 8) begin
        i32_valid = 1; i32_op = op[sent]; i32_amt = 5'(am[sent]); i32_data = dd[sent]; i32_tag = 4'(sent);
      end else i32_valid = 0;
      #1;
      if (held) begin
        n_vec++;
        if (o32_valid !== 1 || o32_data !== held_d || o32_tag !== held_t || o32_err !== held_e)
          begin n_err++; $display("FAIL b2b_stall_hold: valid=%b data=%h tag=%h want 1 %h %h",
                                 o32_valid, o32_data, o32_tag, held_d, held_t); end
      end
      if (q.size() == 2) begin
        n_vec++;
        if (o32_valid !== 1) begin n_err++; $display("FAIL b2b_no_bubble: out_valid=%b want 1", o32_valid); end
      end
      if (o32_valid && o32_ready) begin
        n_vec++;
        if (q.size() == 0) begin n_err++; $display("FAIL b2b_spurious: data=%h want none", o32_data); end
        else begin
          x = q.pop_front();
          if ({32'h0, o32_data} !== x.d || o32_tag !== x.t || o32_err !== x.e)
            begin n_err++; $display("FAIL b2b_result: data=%h tag=%h err=%b want %h %h %b",
                                   o32_data, o32_tag, o32_err, x.d[31:0], x.t, x.e); end
        end
        recv++;
      end
      held = o32_valid && !o32_ready;
      held_d = o32_data; held_t = o32_tag; held_e = o32_err;
      if (i32_valid && i32_ready) begin
        x.d = model(32, int'(op[sent]), am[sent], {32'h0, dd[sent]}, x.e);
        x.t = 4'(sent);
        q.push_back(x);
        sent++;
      end
    end
    @(negedge clk);
    i32_valid = 0; o32_ready = 1;
    n_vec++;
    if (recv != 8) begin n_err++; $display("FAIL b2b_count: got %0d results want 8", recv); end
  endtask

  task automatic test_full;
    exp_t        q[$];
    exp_t        x;
    int          acc;
    logic [31:0] d;
    acc = 0;
    o32_ready = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      d = $urandom;
      i32_valid = 1; i32_op = 3'd2; i32_amt = 0; i32_data = d; i32_tag = 4'(acc + 8);
      #1;
      if (!i32_ready) break;
      x.d = model(32, 2, 0, {32'h0, d}, x.e); x.t = 4'(acc + 8);
      q.push_back(x);
      acc++;
    end
    n_vec++;
    if (acc != 2 || i32_ready !== 0)
      begin n_err++; $display("FAIL full_accepts: accepted=%0d in_ready=%b want 2 and 0", acc, i32_ready); end
    x.d = model(32, 2, 0, {32'h0, i32_data}, x.e); x.t = i32_tag;
    q.push_back(x);
    o32_ready = 1;
    #1;
    n_vec++;
    if (i32_ready !== 1 || o32_valid !== 1 || {32'h0, o32_data} !== q[0].d || o32_tag !== q[0].t)
      begin n_err++; $display("FAIL full_accept_emit: in_ready=%b out_valid=%b data=%h tag=%h want 1 1 %h %h",
                             i32_ready, o32_valid, o32_data, o32_tag, q[0].d[31:0], q[0].t); end
    @(posedge clk);
    @(negedge clk);
    i32_valid = 0;
    for (int k = 1; k < 3; k++) begin
      #1;
      n_vec++;
      if (o32_valid !== 1 || {32'h0, o32_data} !== q[k].d || o32_tag !== q[k].t)
        begin n_err++; $display("FAIL full_drain%0d: valid=%b data=%h tag=%h want 1 %h %h",
                               k, o32_valid, o32_data, o32_tag, q[k].d[31:0], q[k].t); end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (o32_valid !== 0 || busy32 !== 0)
      begin n_err++; $display("FAIL full_empty: valid=%b busy=%b want 0 0", o32_valid, busy32); end
  endtask

  task automatic test_reset_inflight;
    int seen;
    o32_ready = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i32_valid = 1; i32_op = 3'd0; i32_amt = 5'(k + 1); i32_data = $urandom; i32_tag = 4'hF;
    end
    @(negedge clk);
    i32_valid = 0;
    #1;
    n_vec++;
    if (busy32 !== 1) begin n_err++; $display("FAIL inflight_busy: busy=%b want 1", busy32); end
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    n_vec++;
    if (o32_valid !== 0 || busy32 !== 0 || i32_ready !== 1 || o32_data !== 0 || o32_tag !== 0)
      begin n_err++; $display("FAIL inflight_reset: valid=%b busy=%b in_ready=%b data=%h tag=%h want 0 0 1 0 0",
                             o32_valid, busy32, i32_ready, o32_data, o32_tag); end
    o32_ready = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (o32_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL inflight_stale: %0d stale results want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed(0);
    test_directed(1);
    test_random(0, 30);
    test_random(1, 30);
    test_back_to_back();
    test_full();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
